// File: rtl/cache_pkg.sv
// Shared geometry and types for the 4-way, 256-set data cache controller.
package cache_pkg;

    localparam int NUM_WAYS  = 4;
    localparam int NUM_SETS  = 256;
    localparam int INDEX_LSB = 2;
    localparam int INDEX_W   = 8;

    typedef logic [1:0] way_t;
    typedef logic [1:0] age_t;
    typedef age_t [NUM_WAYS-1:0] set_ages_t;

    // Way N starts with age N: way 0 is MRU, way 3 is the first victim.
    localparam set_ages_t RESET_AGES = {2'd3, 2'd2, 2'd1, 2'd0};

    localparam age_t LRU_AGE = 2'd3;

    function automatic way_t lowest_set(input logic [NUM_WAYS-1:0] flags);
        way_t way;
        if (flags[0]) begin
            way = 2'd0;
        end else if (flags[1]) begin
            way = 2'd1;
        end else if (flags[2]) begin
            way = 2'd2;
        end else if (flags[3]) begin
            way = 2'd3;
        end else begin
            way = 2'd0;
        end
        return way;
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Datapath-to-controller bundle: access address, per-way match/empty flags, selected way.
interface cache_controller_if;
    import cache_pkg::*;

    logic [31:0] Addr;
    logic        Tag0_equal;
    logic        Tag1_equal;
    logic        Tag2_equal;
    logic        Tag3_equal;
    logic        Empty_0;
    logic        Empty_1;
    logic        Empty_2;
    logic        Empty_3;
    logic        Hit;
    logic        Usecache;
    way_t        BLK_NUM;

    modport master (
        output Addr, Tag0_equal, Tag1_equal, Tag2_equal, Tag3_equal,
        output Empty_0, Empty_1, Empty_2, Empty_3, Hit, Usecache,
        input  BLK_NUM
    );

    modport slave (
        input  Addr, Tag0_equal, Tag1_equal, Tag2_equal, Tag3_equal,
        input  Empty_0, Empty_1, Empty_2, Empty_3, Hit, Usecache,
        output BLK_NUM
    );

endinterface

// File: rtl/lru_age_update.sv
// True-LRU age update for one set: the touched way becomes MRU, younger ways age by one.
module lru_age_update
    import cache_pkg::*;
(
    input  set_ages_t ages_i,
    input  way_t      way_i,
    output set_ages_t ages_o
);

    age_t touched_age_s;

    assign touched_age_s = ages_i[way_i];

    // Ways older than the touched one keep their age, so the set stays a permutation.
    always_comb begin
        ages_o = ages_i;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (w == int'(way_i)) begin
                ages_o[w] = 2'd0;
            end else if (ages_i[w] < touched_age_s) begin
                ages_o[w] = ages_i[w] + 2'd1;
            end else begin
                ages_o[w] = ages_i[w];
            end
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Way selection (hit > empty > LRU victim) and per-set true-LRU state for the data cache.
module cache_controller
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    cache_controller_if.slave  bus
);

    logic [INDEX_W-1:0]  index_s;
    logic [NUM_WAYS-1:0] tag_eq_s;
    logic [NUM_WAYS-1:0] empty_s;
    logic                unused_addr_s;
    set_ages_t           ages_q [NUM_SETS];
    set_ages_t           cur_ages_s;
    set_ages_t           ages_d;
    way_t                victim_s;
    way_t                blk_num_s;

    assign index_s       = bus.Addr[INDEX_LSB +: INDEX_W];
    assign unused_addr_s = ^{bus.Addr[31:INDEX_LSB+INDEX_W], bus.Addr[INDEX_LSB-1:0]};
    assign tag_eq_s      = {bus.Tag3_equal, bus.Tag2_equal, bus.Tag1_equal, bus.Tag0_equal};
    assign empty_s       = {bus.Empty_3, bus.Empty_2, bus.Empty_1, bus.Empty_0};
    assign cur_ages_s    = ages_q[index_s];

    // Victim finder: the single way of the indexed set carrying the oldest age.
    always_comb begin
        if (cur_ages_s[0] == LRU_AGE) begin
            victim_s = 2'd0;
        end else if (cur_ages_s[1] == LRU_AGE) begin
            victim_s = 2'd1;
        end else if (cur_ages_s[2] == LRU_AGE) begin
            victim_s = 2'd2;
        end else begin
            victim_s = 2'd3;
        end
    end

    // Way select; a hit with no match flag set still falls back to way 0.
    always_comb begin
        if (bus.Hit) begin
            blk_num_s = lowest_set(tag_eq_s);
        end else if (|empty_s) begin
            blk_num_s = lowest_set(empty_s);
        end else begin
            blk_num_s = victim_s;
        end
    end

    assign bus.BLK_NUM = blk_num_s;

    lru_age_update u_lru_age_update (
        .ages_i (cur_ages_s),
        .way_i  (blk_num_s),
        .ages_o (ages_d)
    );

    // Per-set age storage; only the indexed set changes, and only on the first access cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                ages_q[s] <= RESET_AGES;
            end
        end else if (bus.Usecache) begin
            ages_q[index_s] <= ages_d;
        end else begin
            ages_q[index_s] <= cur_ages_s;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed table-driven bench for cache_controller plus multi-cycle LRU and reset sequences.
module tb_cache_controller;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    cache_controller_if bus ();

    cache_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  tag;
        logic [3:0]  empty;
        logic        hit;
        logic        use_c;
        logic [1:0]  exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic drive(input logic [31:0] addr, input logic [3:0] tag,
                         input logic [3:0] empty, input logic hit, input logic use_c);
        bus.Addr       = addr;
        bus.Tag0_equal = tag[0];
        bus.Tag1_equal = tag[1];
        bus.Tag2_equal = tag[2];
        bus.Tag3_equal = tag[3];
        bus.Empty_0    = empty[0];
        bus.Empty_1    = empty[1];
        bus.Empty_2    = empty[2];
        bus.Empty_3    = empty[3];
        bus.Hit        = hit;
        bus.Usecache   = use_c;
    endtask

    task automatic check(input string name, input logic [1:0] exp);
        total++;
        if (bus.BLK_NUM !== exp) begin
            bad++;
            $display("FAIL %s: BLK_NUM=%0d expected %0d", name, bus.BLK_NUM, exp);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(32'h0, 4'h0, 4'hF, 1'b0, 1'b0);

        // addr, tag, empty, hit, use, expected way
        vecs.push_back('{32'h0000_0000, 4'h0, 4'hF, 1'b0, 1'b1, 2'd0, "rst_all_empty"});
        vecs.push_back('{32'h0000_0000, 4'h0, 4'hE, 1'b0, 1'b0, 2'd1, "set0_empty1"});
        vecs.push_back('{32'h0000_0000, 4'h0, 4'h0, 1'b0, 1'b0, 2'd3, "set0_mru_touch_noop"});
        vecs.push_back('{32'h0000_0004, 4'h4, 4'h2, 1'b1, 1'b1, 2'd2, "set1_hit_beats_empty"});
        vecs.push_back('{32'h0000_0004, 4'h0, 4'h0, 1'b0, 1'b0, 2'd3, "set1_victim3"});
        vecs.push_back('{32'h0000_0004, 4'h8, 4'h0, 1'b1, 1'b1, 2'd3, "set1_hit3"});
        vecs.push_back('{32'h0000_0004, 4'h0, 4'h0, 1'b0, 1'b0, 2'd1, "set1_victim_after"});
        vecs.push_back('{32'h0000_0014, 4'h0, 4'h0, 1'b0, 1'b1, 2'd3, "set5_touch3"});
        vecs.push_back('{32'h0000_0014, 4'h0, 4'h0, 1'b0, 1'b1, 2'd2, "set5_touch2"});
        vecs.push_back('{32'h0000_0014, 4'h0, 4'h0, 1'b0, 1'b1, 2'd1, "set5_touch1"});
        vecs.push_back('{32'h0000_0014, 4'h0, 4'h0, 1'b0, 1'b1, 2'd0, "set5_touch0"});
        vecs.push_back('{32'h0000_0014, 4'h0, 4'h0, 1'b0, 1'b0, 2'd3, "set5_victim_back3"});
        vecs.push_back('{32'h0000_0018, 4'hA, 4'h0, 1'b1, 1'b0, 2'd1, "set6_lowest_hit"});
        vecs.push_back('{32'h0000_0018, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, "set6_hit_no_tag"});
        vecs.push_back('{32'h0000_0018, 4'h0, 4'hC, 1'b0, 1'b0, 2'd2, "set6_lowest_empty"});
        vecs.push_back('{32'h0000_001C, 4'h8, 4'h0, 1'b1, 1'b1, 2'd3, "set7_hit3"});
        vecs.push_back('{32'h0000_001C, 4'h0, 4'h0, 1'b0, 1'b0, 2'd2, "set7_victim2"});
        vecs.push_back('{32'h0000_0020, 4'h0, 4'h0, 1'b0, 1'b0, 2'd3, "set8_isolated"});
        vecs.push_back('{32'hFFFF_FC1F, 4'h0, 4'h0, 1'b0, 1'b0, 2'd2, "set7_upper_bits"});

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].addr, vecs[i].tag, vecs[i].empty, vecs[i].hit, vecs[i].use_c);
            #1;
            check($sformatf("vec%0d_%s", i, vecs[i].name), vecs[i].exp);
            @(negedge clk);
        end

        // Set 4: one Usecache edge, then five stalled edges while Hit flips on way 2.
        drive(32'h0000_0010, 4'h0, 4'h0, 1'b0, 1'b1);
        #1;
        check("stall_first", 2'd3);
        @(negedge clk);
        drive(32'h0000_0010, 4'h0, 4'h0, 1'b0, 1'b0);
        #1;
        check("stall_victim2", 2'd2);
        for (int c = 0; c < 5; c++) begin
            if (c >= 2) begin
                drive(32'h0000_0010, 4'h4, 4'h0, 1'b1, 1'b0);
                #1;
                check($sformatf("stall_hit_c%0d", c), 2'd2);
            end else begin
                drive(32'h0000_0010, 4'h0, 4'h0, 1'b0, 1'b0);
                #1;
                check($sformatf("stall_miss_c%0d", c), 2'd2);
            end
            @(negedge clk);
        end
        drive(32'h0000_0010, 4'h0, 4'h0, 1'b0, 1'b0);
        #1;
        check("stall_single_update", 2'd2);

        // Asynchronous reset between edges restores ages of every set.
        @(negedge clk);
        drive(32'h0000_001C, 4'h0, 4'h0, 1'b0, 1'b0);
        #1;
        check("pre_rst_set7", 2'd2);
        rst_n = 1'b0;
        #1;
        check("async_rst_set7", 2'd3);
        drive(32'h0000_0004, 4'h0, 4'h0, 1'b0, 1'b0);
        #1;
        check("async_rst_set1", 2'd3);

        // Usecache held through an edge while in reset must have no effect.
        drive(32'h0000_001C, 4'h0, 4'h0, 1'b0, 1'b1);
        @(negedge clk);
        drive(32'h0000_001C, 4'h0, 4'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        check("use_in_rst_ignored", 2'd3);

        // First Usecache edge after release updates normally.
        @(negedge clk);
        drive(32'h0000_001C, 4'h0, 4'h0, 1'b0, 1'b1);
        #1;
        check("post_rst_touch", 2'd3);
        @(negedge clk);
        drive(32'h0000_001C, 4'h0, 4'h0, 1'b0, 1'b0);
        #1;
        check("post_rst_victim2", 2'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
